// File: rtl/switch_responder.sv
// rtl/switch_responder.sv - egress responder: round-robin frame grant, stall abort, source drain
// Define PACKET_FILTER_STATS_EN to enable the frames_fwd/frames_abt counters.
module switch_responder #(
   parameter int NUM_INGRESS       = 4,
   parameter int DEST_WIDTH        = 2,
   parameter int EGRESS_ID         = 0,
   parameter int DATA_WIDTH        = 16,
   parameter int TIMEOUT_CTR_WIDTH = 3
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_INGRESS-1:0]            ing_valid,
   input  logic [NUM_INGRESS*DEST_WIDTH-1:0] ing_dest,
   input  logic [NUM_INGRESS*DATA_WIDTH-1:0] ing_data,
   input  logic [NUM_INGRESS-1:0]            ing_last,
   output logic [NUM_INGRESS-1:0]            ing_ready,
   output logic                              egr_valid,
   output logic [DATA_WIDTH-1:0]             egr_data,
   output logic                              egr_last,
   output logic                              egr_abort,
   input  logic                              egr_ready,
   output logic [15:0]                       frames_fwd,
   output logic [15:0]                       frames_abt
);
   localparam int IW = $clog2(NUM_INGRESS);
   localparam logic [TIMEOUT_CTR_WIDTH-1:0] STALL_LIMIT = '1;

   typedef enum logic [1:0] {S_IDLE, S_PASS, S_ABORT} state_t;

   state_t                       r_state;
   logic [IW-1:0]                r_rr_ptr;
   logic [IW-1:0]                r_grant;
   logic [TIMEOUT_CTR_WIDTH-1:0] r_stall_ctr;
   logic [NUM_INGRESS-1:0]       r_drain_mask;

   logic [NUM_INGRESS-1:0]       w_req;
   logic                         w_req_any;
   logic [IW-1:0]                w_pick;
   logic [IW-1:0]                w_sel;
   int                           w_idx;
   logic [IW-1:0]                w_grant_inc;
   logic                         w_g_valid;
   logic                         w_g_last;
   logic [DATA_WIDTH-1:0]        w_g_data;
   logic [TIMEOUT_CTR_WIDTH-1:0] w_stall_nxt;
   logic                         w_fwd_evt;
   logic                         w_abt_evt;

   always_comb begin
      w_req = '0;
      for (int i = 0; i < NUM_INGRESS; i++) begin
         w_req[i] = ing_valid[i] & ~r_drain_mask[i] &
                    (ing_dest[i*DEST_WIDTH +: DEST_WIDTH] == DEST_WIDTH'(EGRESS_ID));
      end
   end

   // Scan from the far end so the candidate closest to rr_ptr is assigned last and wins.
   always_comb begin
      w_req_any = 1'b0;
      w_pick    = '0;
      w_idx     = 0;
      w_sel     = '0;
      for (int k = NUM_INGRESS - 1; k >= 0; k--) begin
         w_idx = (int'(r_rr_ptr) + k) % NUM_INGRESS;
         w_sel = IW'(w_idx);
         if (w_req[w_sel]) begin
            w_req_any = 1'b1;
            w_pick    = w_sel;
         end
      end
   end

   assign w_g_valid   = ing_valid[r_grant];
   assign w_g_last    = ing_last[r_grant];
   assign w_g_data    = ing_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
   assign w_grant_inc = (r_grant == IW'(NUM_INGRESS - 1)) ? '0 : r_grant + 1'b1;
   assign w_stall_nxt = r_stall_ctr + 1'b1;
   assign w_fwd_evt   = (r_state == S_PASS) & w_g_valid & w_g_last & egr_ready;
   assign w_abt_evt   = (r_state == S_ABORT) & egr_ready;

   always_comb begin
      ing_ready = r_drain_mask;
      egr_valid = 1'b0;
      egr_data  = '0;
      egr_last  = 1'b0;
      egr_abort = 1'b0;
      case (r_state)
         S_PASS: begin
            egr_valid          = w_g_valid;
            egr_data           = w_g_data;
            egr_last           = w_g_last;
            ing_ready[r_grant] = egr_ready;
         end
         S_ABORT: begin
            egr_valid          = 1'b1;
            egr_last           = 1'b1;
            egr_abort          = 1'b1;
            ing_ready[r_grant] = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_rr_ptr     <= '0;
         r_grant      <= '0;
         r_stall_ctr  <= '0;
         r_drain_mask <= '0;
      end else begin
         // Drained sources release on their own last beat; an abort below may re-arm the granted bit.
         r_drain_mask <= r_drain_mask & ~(ing_valid & ing_last);
         case (r_state)
            S_IDLE: begin
               r_stall_ctr <= '0;
               if (w_req_any) begin
                  r_grant <= w_pick;
                  r_state <= S_PASS;
               end
            end
            S_PASS: begin
               if (w_fwd_evt) begin
                  r_state     <= S_IDLE;
                  r_rr_ptr    <= w_grant_inc;
                  r_stall_ctr <= '0;
               end else if (w_g_valid) begin
                  r_stall_ctr <= '0;
               end else begin
                  r_stall_ctr <= w_stall_nxt;
                  if (w_stall_nxt == STALL_LIMIT) r_state <= S_ABORT;
               end
            end
            S_ABORT: begin
               r_stall_ctr <= '0;
               if (w_abt_evt) begin
                  r_drain_mask[r_grant] <= 1'b1;
                  r_rr_ptr              <= w_grant_inc;
                  r_state               <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef PACKET_FILTER_STATS_EN
   logic [15:0] r_frames_fwd;
   logic [15:0] r_frames_abt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_frames_fwd <= '0;
         r_frames_abt <= '0;
      end else begin
         if (w_fwd_evt) r_frames_fwd <= r_frames_fwd + 16'd1;
         if (w_abt_evt) r_frames_abt <= r_frames_abt + 16'd1;
      end
   end

   assign frames_fwd = r_frames_fwd;
   assign frames_abt = r_frames_abt;
`else
   assign frames_fwd = '0;
   assign frames_abt = '0;
`endif

endmodule

// File: tb/tb_switch_responder.sv
// tb/tb_switch_responder.sv - scoreboard bench for switch_responder
module tb_switch_responder;
   typedef struct packed {logic idle; logic [1:0] dest; logic last; logic [15:0] data;} beat_t;
   typedef struct packed {logic abort; logic last; logic [15:0] data;} exp_t;

`ifdef PACKET_FILTER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [3:0]  ing_valid;
   logic [7:0]  ing_dest;
   logic [63:0] ing_data;
   logic [3:0]  ing_last;
   logic [3:0]  ing_ready;
   logic        egr_valid;
   logic [15:0] egr_data;
   logic        egr_last;
   logic        egr_abort;
   logic        egr_ready;
   logic [15:0] frames_fwd;
   logic [15:0] frames_abt;

   int n_vec  = 0;
   int n_miss = 0;

   beat_t iq[4][$];
   exp_t  exp_q[$];
   bit    shown[4];
   bit    shown_idle[4];
   bit    flush_tgl[4];
   bit    flush_seen[4];
   logic [3:0] hs_q;
   bit    held_v;
   logic [15:0] held_d;

   switch_responder dut (
      .clk(clk), .reset(reset),
      .ing_valid(ing_valid), .ing_dest(ing_dest), .ing_data(ing_data), .ing_last(ing_last),
      .ing_ready(ing_ready),
      .egr_valid(egr_valid), .egr_data(egr_data), .egr_last(egr_last), .egr_abort(egr_abort),
      .egr_ready(egr_ready),
      .frames_fwd(frames_fwd), .frames_abt(frames_abt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_cnt(input int n);
      return STATS ? 16'(n) : 16'h0000;
   endfunction

   task automatic push_beat(input int i, input logic [15:0] d, input logic l, input logic [1:0] dest = 2'd0);
      beat_t b;
      b = '{idle: 1'b0, dest: dest, last: l, data: d};
      iq[i].push_back(b);
   endtask

   task automatic push_idle(input int i, input int n);
      beat_t b;
      b = '{idle: 1'b1, dest: 2'd0, last: 1'b0, data: 16'h0};
      for (int k = 0; k < n; k++) iq[i].push_back(b);
   endtask

   task automatic expect_beat(input logic [15:0] d, input logic l, input logic a = 1'b0);
      exp_t e;
      e = '{abort: a, last: l, data: d};
      exp_q.push_back(e);
   endtask

   function automatic bit busy();
      bit b;
      b = (exp_q.size() != 0);
      for (int i = 0; i < 4; i++) if (iq[i].size() != 0) b = 1'b1;
      return b;
   endfunction

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy() && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({name, "_complete"}, 32'(n < 400), 32'd1);
      if (n >= 400) exp_q.delete();
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_egr_valid(input string name);
      int n;
      n = 0;
      while (!egr_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, "_egr_valid_seen"}, 32'(egr_valid), 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
   endtask

   // Per-ingress source: one queue entry per cycle for idle gaps, beats held until accepted.
   initial begin
      ing_valid = '0;
      ing_dest  = '0;
      ing_data  = '0;
      ing_last  = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (flush_tgl[i] != flush_seen[i]) begin
               flush_seen[i] = flush_tgl[i];
               iq[i].delete();
               shown[i] = 1'b0;
            end
            if (shown[i] && (hs_q[i] || shown_idle[i]) && iq[i].size() > 0) void'(iq[i].pop_front());
            if (iq[i].size() > 0) begin
               shown[i]            = 1'b1;
               shown_idle[i]       = iq[i][0].idle;
               ing_valid[i]        = ~iq[i][0].idle;
               ing_last[i]         = iq[i][0].last;
               ing_data[i*16 +: 16] = iq[i][0].data;
               ing_dest[i*2 +: 2]  = iq[i][0].dest;
            end else begin
               shown[i]      = 1'b0;
               shown_idle[i] = 1'b0;
               ing_valid[i]  = 1'b0;
               ing_last[i]   = 1'b0;
            end
         end
      end
   end

   initial begin
      exp_t e;
      hs_q   = '0;
      held_v = 1'b0;
      held_d = '0;
      forever begin
         @(negedge clk);
         hs_q = ing_valid & ing_ready;
         if (egr_valid && egr_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL egr_unexpected: actual beat %h last %b abort %b required none", egr_data, egr_last, egr_abort);
            end else begin
               e = exp_q.pop_front();
               check("egr_beat", {14'd0, egr_abort, egr_last, egr_data}, {14'd0, e.abort, e.last, e.data});
            end
         end
         if (held_v) check("egr_hold_stable", {15'd0, egr_valid, egr_data}, {15'd0, 1'b1, held_d});
         held_v = egr_valid & ~egr_ready;
         held_d = egr_data;
      end
   end

   initial begin
      bit saw_ready;
      bit saw_valid;
      reset     = 1'b1;
      egr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_ing_ready", 32'(ing_ready), 32'h0);
      check("rst_egr", {28'd0, egr_valid, egr_last, egr_abort, 1'b0}, 32'h0);
      check("rst_egr_data", 32'(egr_data), 32'h0);
      check("rst_counters", {frames_fwd, frames_abt}, 32'h0);

      // single 3-beat frame, grant latency
      push_beat(1, 16'h00A1, 1'b0);
      push_beat(1, 16'h00A2, 1'b0);
      push_beat(1, 16'h00A3, 1'b1);
      expect_beat(16'h00A1, 1'b0);
      expect_beat(16'h00A2, 1'b0);
      expect_beat(16'h00A3, 1'b1);
      for (int n = 0; n < 20 && !ing_valid[1]; n++) @(negedge clk);
      check("lat_req_cycle_egr_valid", 32'(egr_valid), 32'd0);
      @(negedge clk);
      check("lat_next_cycle_egr_valid", 32'(egr_valid), 32'd1);
      wait_idle("t1");
      check("t1_frames_fwd", 32'(frames_fwd), 32'(exp_cnt(1)));

      // round robin 0,2,3 then wrap to 0
      do_reset();
      push_beat(0, 16'h0101, 1'b0); push_beat(0, 16'h0102, 1'b1);
      push_beat(0, 16'h0103, 1'b0); push_beat(0, 16'h0104, 1'b1);
      push_beat(2, 16'h0201, 1'b0); push_beat(2, 16'h0202, 1'b1);
      push_beat(3, 16'h0301, 1'b0); push_beat(3, 16'h0302, 1'b1);
      expect_beat(16'h0101, 1'b0); expect_beat(16'h0102, 1'b1);
      expect_beat(16'h0201, 1'b0); expect_beat(16'h0202, 1'b1);
      expect_beat(16'h0301, 1'b0); expect_beat(16'h0302, 1'b1);
      expect_beat(16'h0103, 1'b0); expect_beat(16'h0104, 1'b1);
      wait_idle("t2");
      check("t2_frames_fwd", 32'(frames_fwd), 32'(exp_cnt(4)));

      // foreign destination is ignored
      push_beat(2, 16'h0222, 1'b1, 2'd1);
      saw_ready = 1'b0;
      saw_valid = 1'b0;
      repeat (10) begin
         @(negedge clk);
         saw_ready |= ing_ready[2];
         saw_valid |= egr_valid;
      end
      check("t3_ing_ready2", 32'(saw_ready), 32'd0);
      check("t3_egr_valid", 32'(saw_valid), 32'd0);
      flush_tgl[2] = ~flush_tgl[2];
      repeat (3) @(negedge clk);

      // 6-cycle stall is tolerated
      push_beat(1, 16'h0C01, 1'b0);
      push_idle(1, 6);
      push_beat(1, 16'h0C02, 1'b1);
      expect_beat(16'h0C01, 1'b0);
      expect_beat(16'h0C02, 1'b1);
      wait_idle("t4a");
      check("t4a_frames_abt", 32'(frames_abt), 32'd0);

      // 7-cycle stall aborts; late beats drained while ingress0 passes
      push_beat(1, 16'h0B01, 1'b0);
      push_idle(1, 7);
      push_beat(1, 16'h0B02, 1'b0);
      push_beat(1, 16'h0B03, 1'b1);
      push_idle(0, 10);
      push_beat(0, 16'h0D01, 1'b0);
      push_beat(0, 16'h0D02, 1'b0);
      push_beat(0, 16'h0D03, 1'b1);
      expect_beat(16'h0B01, 1'b0);
      expect_beat(16'h0000, 1'b1, 1'b1);
      expect_beat(16'h0D01, 1'b0);
      expect_beat(16'h0D02, 1'b0);
      expect_beat(16'h0D03, 1'b1);
      wait_idle("t4b");
      check("t4b_frames_abt", 32'(frames_abt), 32'(exp_cnt(1)));
      check("t4b_frames_fwd", 32'(frames_fwd), 32'(exp_cnt(6)));

      // egress backpressure is not a stall
      push_beat(0, 16'h0E01, 1'b0); push_beat(0, 16'h0E02, 1'b0);
      push_beat(0, 16'h0E03, 1'b0); push_beat(0, 16'h0E04, 1'b1);
      expect_beat(16'h0E01, 1'b0); expect_beat(16'h0E02, 1'b0);
      expect_beat(16'h0E03, 1'b0); expect_beat(16'h0E04, 1'b1);
      wait_egr_valid("t5");
      @(posedge clk);
      #1 egr_ready = 1'b0;
      repeat (10) @(posedge clk);
      #1 egr_ready = 1'b1;
      wait_idle("t5");
      check("t5_frames_abt", 32'(frames_abt), 32'(exp_cnt(1)));
      check("t5_frames_fwd", 32'(frames_fwd), 32'(exp_cnt(7)));

      // reset in the middle of a frame
      push_beat(2, 16'h0F01, 1'b0); push_beat(2, 16'h0F02, 1'b0);
      push_beat(2, 16'h0F03, 1'b0); push_beat(2, 16'h0F04, 1'b1);
      expect_beat(16'h0F01, 1'b0);
      expect_beat(16'h0F02, 1'b0);
      wait_egr_valid("t6");
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      flush_tgl[2] = ~flush_tgl[2];
      @(negedge clk);
      check("t6_rst_ing_ready", 32'(ing_ready), 32'h0);
      check("t6_rst_egr", {28'd0, egr_valid, egr_last, egr_abort, 1'b0}, 32'h0);
      check("t6_rst_egr_data", 32'(egr_data), 32'h0);
      check("t6_rst_counters", {frames_fwd, frames_abt}, 32'h0);
      check("t6_pending_beats", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      push_beat(3, 16'h0301, 1'b0); push_beat(3, 16'h0302, 1'b1);
      push_beat(0, 16'h1001, 1'b0); push_beat(0, 16'h1002, 1'b1);
      expect_beat(16'h1001, 1'b0); expect_beat(16'h1002, 1'b1);
      expect_beat(16'h0301, 1'b0); expect_beat(16'h0302, 1'b1);
      wait_idle("t6");
      check("t6_frames_fwd", 32'(frames_fwd), 32'(exp_cnt(2)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
